redun_sq_loop_ctrl: RTL

//  Host-side sequencer driving redun_wrapper's start/data/valid/locked interface. Loads a seed,

---
 rtl/redun_mont_pkg.sv | 19 +
 rtl/redun_sq_loop_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/redun_mont_pkg.sv
// Shared types for the redundant Montgomery squaring path.
// Holds the word layout of redun0_t and the loop sequencer state encoding.
package redun_mont_pkg;

  localparam int NUM_WRDS = 4;
  localparam int WRD_BITS = 16;

  typedef logic [NUM_WRDS-1:0][WRD_BITS-1:0] redun0_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    ISSUE,
    WAIT_RES,
    DONE,
    ERR
  } sq_ctrl_state_t;

endpackage

// File: rtl/redun_sq_loop_ctrl.sv
// Host-side squaring loop sequencer for redun_wrapper: seed, issue, feed back, count.
// Ports: i_clk/i_rst_n, host i_go/i_abort/i_iter/i_init, status o_busy/o_done/o_err,
// o_result/o_iter_cnt, wrapper o_start/o_sq_in, i_sq_out/i_valid/i_locked.
module redun_sq_loop_ctrl
  import redun_mont_pkg::*;
#(
  parameter int ITER_BITS   = 64,
  parameter int LOCK_STABLE = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_go,
  input  logic                 i_abort,
  input  logic [ITER_BITS-1:0] i_iter,
  input  redun0_t              i_init,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output redun0_t              o_result,
  output logic [ITER_BITS-1:0] o_iter_cnt,
  output logic                 o_start,
  output redun0_t              o_sq_in,
  input  redun0_t              i_sq_out,
  input  logic                 i_valid,
  input  logic                 i_locked
);

  localparam int LW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  sq_ctrl_state_t       state, state_n;
  logic [ITER_BITS-1:0] iter_q, iter_n;
  logic [ITER_BITS-1:0] cnt_n, cnt_inc;
  logic [LW-1:0]        lock_q, lock_n;
  logic [TW-1:0]        tmo_q, tmo_n;
  redun0_t              result_n, sqin_n;
  logic                 start_n, done_n;

  assign cnt_inc = o_iter_cnt + ITER_BITS'(1);

  always_comb begin
    state_n  = state;
    iter_n   = iter_q;
    lock_n   = lock_q;
    tmo_n    = tmo_q;
    result_n = o_result;
    cnt_n    = o_iter_cnt;
    sqin_n   = o_sq_in;
    start_n  = 1'b0;
    done_n   = 1'b0;
    if (i_abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE, ERR: begin
          if (i_go) begin
            iter_n   = i_iter;
            result_n = i_init;
            cnt_n    = '0;
            lock_n   = '0;
            if (i_iter == '0) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              state_n = WAIT_LOCK;
            end
          end
        end
        WAIT_LOCK: begin
          if (!i_locked) begin
            lock_n = '0;
          end else if (lock_q == LOCK_LAST) begin
            state_n = ISSUE;
          end else begin
            lock_n = lock_q + LW'(1);
          end
        end
        ISSUE: begin
          // start is registered, so a lost lock here suppresses it
          if (!i_locked) begin
            state_n = ERR;
          end else begin
            start_n = 1'b1;
            sqin_n  = o_result;
            tmo_n   = '0;
            state_n = WAIT_RES;
          end
        end
        WAIT_RES: begin
          // a response in the expiry cycle still counts
          if (!i_locked) begin
            state_n = ERR;
          end else if (i_valid) begin
            result_n = i_sq_out;
            cnt_n    = cnt_inc;
            if (cnt_inc == iter_q) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              state_n = ISSUE;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_n = ERR;
          end else begin
            tmo_n = tmo_q + TW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      iter_q     <= '0;
      lock_q     <= '0;
      tmo_q      <= '0;
      o_result   <= '0;
      o_iter_cnt <= '0;
      o_sq_in    <= '0;
      o_start    <= 1'b0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state      <= state_n;
      iter_q     <= iter_n;
      lock_q     <= lock_n;
      tmo_q      <= tmo_n;
      o_result   <= result_n;
      o_iter_cnt <= cnt_n;
      o_sq_in    <= sqin_n;
      o_start    <= start_n;
      o_done     <= done_n;
      o_busy     <= state_n inside {WAIT_LOCK, ISSUE, WAIT_RES};
      o_err      <= (state_n == ERR);
    end
  end

endmodule
